// File: rtl/bcd_counter_mod.sv
// bcd_counter_mod: two-digit BCD counter with modulus MODULO (2..100) and
// reset value INIT. The value is kept as a ones digit, a tens digit and a
// matching binary copy, so no conversion logic sits on the output path.
// Optional feature macro: BCD_CNT_DOWN_EN adds the up_dn port and down counting.
// Per-cycle priority: clear, then load, then a tick (tick_in && enable).
module bcd_counter_mod #(
    parameter int MODULO = 60,
    parameter int INIT   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_in,
    input  logic       enable,
`ifdef BCD_CNT_DOWN_EN
    input  logic       up_dn,
`endif
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_dec1,
    input  logic [3:0] load_dec10,
    output logic [3:0] dec1,
    output logic [3:0] dec10,
    output logic [6:0] cnt_bin,
    output logic       carry,
    output logic       load_err
);

    // Elaboration guards: an out-of-range modulus or reset value must not build.
    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
        $error("bcd_counter_mod: MODULO must be in 2..100");
    end
    if (INIT < 0 || INIT >= MODULO) begin : g_bad_init
        $error("bcd_counter_mod: INIT must be in 0..MODULO-1");
    end

    // Digit and binary forms of the terminal value and the reset value.
    localparam logic [3:0] TOP_D1   = 4'((MODULO - 1) % 10);
    localparam logic [3:0] TOP_D10  = 4'((MODULO - 1) / 10);
    localparam logic [6:0] TOP_BIN  = 7'(MODULO - 1);
    localparam logic [3:0] INIT_D1  = 4'(INIT % 10);
    localparam logic [3:0] INIT_D10 = 4'(INIT / 10);
    localparam logic [6:0] INIT_BIN = 7'(INIT);
    localparam logic [7:0] MOD_W    = 8'(MODULO);

    logic [3:0] dec1_reg,     dec1_next;
    logic [3:0] dec10_reg,    dec10_next;
    logic [6:0] cnt_bin_reg,  cnt_bin_next;
    logic       carry_reg,    carry_next;
    logic       load_err_reg, load_err_next;

    logic       count_up;
    logic       at_top;
    logic       at_zero;
    logic       load_ok;
    logic [7:0] load_bin;

`ifdef BCD_CNT_DOWN_EN
    assign count_up = up_dn;
`else
    assign count_up = 1'b1;
`endif

    // The terminal tests compare digits directly, so they cost two small
    // comparators rather than a binary compare against MODULO-1.
    assign at_top  = (dec1_reg == TOP_D1) && (dec10_reg == TOP_D10);
    assign at_zero = (dec1_reg == 4'd0) && (dec10_reg == 4'd0);

    // Load is accepted only for real BCD digits forming a value below MODULO.
    // 8 bits covers the worst case 15*10+15 of non-BCD digits without wrap.
    assign load_bin = ({4'd0, load_dec10} * 8'd10) + {4'd0, load_dec1};
    assign load_ok  = (load_dec1 <= 4'd9) && (load_dec10 <= 4'd9) && (load_bin < MOD_W);

    // Next-state selection: clear beats load beats counting; strobes default low.
    always_comb begin
        dec1_next     = dec1_reg;
        dec10_next    = dec10_reg;
        cnt_bin_next  = cnt_bin_reg;
        carry_next    = 1'b0;
        load_err_next = 1'b0;
        if (clear) begin
            dec1_next    = 4'd0;
            dec10_next   = 4'd0;
            cnt_bin_next = 7'd0;
        end else if (load) begin
            if (load_ok) begin
                dec1_next    = load_dec1;
                dec10_next   = load_dec10;
                cnt_bin_next = load_bin[6:0];
            end else begin
                load_err_next = 1'b1;
            end
        end else if (tick_in && enable) begin
            if (count_up) begin
                if (at_top) begin
                    dec1_next    = 4'd0;
                    dec10_next   = 4'd0;
                    cnt_bin_next = 7'd0;
                    carry_next   = 1'b1;
                end else if (dec1_reg == 4'd9) begin
                    dec1_next    = 4'd0;
                    dec10_next   = dec10_reg + 4'd1;
                    cnt_bin_next = cnt_bin_reg + 7'd1;
                end else begin
                    dec1_next    = dec1_reg + 4'd1;
                    cnt_bin_next = cnt_bin_reg + 7'd1;
                end
            end else begin
                if (at_zero) begin
                    dec1_next    = TOP_D1;
                    dec10_next   = TOP_D10;
                    cnt_bin_next = TOP_BIN;
                    carry_next   = 1'b1;
                end else if (dec1_reg == 4'd0) begin
                    dec1_next    = 4'd9;
                    dec10_next   = dec10_reg - 4'd1;
                    cnt_bin_next = cnt_bin_reg - 7'd1;
                end else begin
                    dec1_next    = dec1_reg - 4'd1;
                    cnt_bin_next = cnt_bin_reg - 7'd1;
                end
            end
        end
    end

    // State register; reset loads INIT and kills any pending carry/load_err pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec1_reg     <= INIT_D1;
            dec10_reg    <= INIT_D10;
            cnt_bin_reg  <= INIT_BIN;
            carry_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            dec1_reg     <= dec1_next;
            dec10_reg    <= dec10_next;
            cnt_bin_reg  <= cnt_bin_next;
            carry_reg    <= carry_next;
            load_err_reg <= load_err_next;
        end
    end

    assign dec1     = dec1_reg;
    assign dec10    = dec10_reg;
    assign cnt_bin  = cnt_bin_reg;
    assign carry    = carry_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_counter_mod.sv
// Self-checking bench for bcd_counter_mod. Instances: MODULO=60/INIT=0,
// MODULO=60/INIT=23 (shared inputs), a MODULO=100 cascade (lo.carry -> hi.tick_in),
// and with BCD_CNT_DOWN_EN a MODULO=24 instance on the shared inputs.
// The reference model keeps each counter as a plain integer value.
module tb_bcd_counter_mod;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       tick = 1'b0, enable = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
    logic [3:0] ld1 = 4'd0, ld10 = 4'd0;
    logic       c_tick = 1'b0, c_clear = 1'b0;

    logic [3:0] m60_d1, m60_d10, i23_d1, i23_d10, lo_d1, lo_d10, hi_d1, hi_d10;
    logic [6:0] m60_bin, i23_bin, lo_bin, hi_bin;
    logic       m60_cy, m60_er, i23_cy, i23_er, lo_cy, lo_er, hi_cy, hi_er;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model state: value, expected carry, expected load_err per instance
    int v60, v23, vlo, vhi;
    bit cy60, er60, cy23, er23, cylo, erlo, cyhi, erhi;

    always #5 clk = ~clk;

    bcd_counter_mod #(.MODULO(60), .INIT(0)) u_m60 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick), .enable(enable),
`ifdef BCD_CNT_DOWN_EN
        .up_dn(up_dn),
`endif
        .clear(clear), .load(load), .load_dec1(ld1), .load_dec10(ld10),
        .dec1(m60_d1), .dec10(m60_d10), .cnt_bin(m60_bin), .carry(m60_cy), .load_err(m60_er));

    bcd_counter_mod #(.MODULO(60), .INIT(23)) u_i23 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick), .enable(enable),
`ifdef BCD_CNT_DOWN_EN
        .up_dn(up_dn),
`endif
        .clear(clear), .load(load), .load_dec1(ld1), .load_dec10(ld10),
        .dec1(i23_d1), .dec10(i23_d10), .cnt_bin(i23_bin), .carry(i23_cy), .load_err(i23_er));

    bcd_counter_mod #(.MODULO(100), .INIT(0)) u_lo (
        .clk(clk), .reset_n(reset_n), .tick_in(c_tick), .enable(1'b1),
`ifdef BCD_CNT_DOWN_EN
        .up_dn(1'b1),
`endif
        .clear(c_clear), .load(1'b0), .load_dec1(4'd0), .load_dec10(4'd0),
        .dec1(lo_d1), .dec10(lo_d10), .cnt_bin(lo_bin), .carry(lo_cy), .load_err(lo_er));

    bcd_counter_mod #(.MODULO(100), .INIT(0)) u_hi (
        .clk(clk), .reset_n(reset_n), .tick_in(lo_cy), .enable(1'b1),
`ifdef BCD_CNT_DOWN_EN
        .up_dn(1'b1),
`endif
        .clear(c_clear), .load(1'b0), .load_dec1(4'd0), .load_dec10(4'd0),
        .dec1(hi_d1), .dec10(hi_d10), .cnt_bin(hi_bin), .carry(hi_cy), .load_err(hi_er));

`ifdef BCD_CNT_DOWN_EN
    logic [3:0] m24_d1, m24_d10;
    logic [6:0] m24_bin;
    logic       m24_cy, m24_er;
    int         v24;
    bit         cy24, er24;

    bcd_counter_mod #(.MODULO(24), .INIT(0)) u_m24 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_dec1(ld1), .load_dec10(ld10),
        .dec1(m24_d1), .dec10(m24_d10), .cnt_bin(m24_bin), .carry(m24_cy), .load_err(m24_er));
`endif

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference behaviour of one counter for one clock edge.
    task automatic model_step(input int modulo, input int cur, input bit clr, input bit ld,
                              input int d1, input int d10, input bit tk, input bit en,
                              input bit up, output int nxt, output bit cy, output bit er);
        nxt = cur;
        cy  = 1'b0;
        er  = 1'b0;
        if (clr) begin
            nxt = 0;
        end else if (ld) begin
            if (d1 <= 9 && d10 <= 9 && (d10 * 10 + d1) < modulo) nxt = d10 * 10 + d1;
            else er = 1'b1;
        end else if (tk && en) begin
            if (up) begin
                if (cur == modulo - 1) begin nxt = 0; cy = 1'b1; end
                else nxt = cur + 1;
            end else begin
                if (cur == 0) begin nxt = modulo - 1; cy = 1'b1; end
                else nxt = cur - 1;
            end
        end
    endtask

    task automatic check_inst(input string nm, input logic [3:0] d1, input logic [3:0] d10,
                              input logic [6:0] bin, input logic cy, input logic er,
                              input int v, input bit ecy, input bit eer);
        check_eq({nm, ".dec1"}, int'(d1), v % 10);
        check_eq({nm, ".dec10"}, int'(d10), v / 10);
        check_eq({nm, ".cnt_bin"}, int'(bin), v);
        check_eq({nm, ".carry"}, int'(cy), int'(ecy));
        check_eq({nm, ".load_err"}, int'(er), int'(eer));
    endtask

    task automatic check_all();
        check_inst("m60", m60_d1, m60_d10, m60_bin, m60_cy, m60_er, v60, cy60, er60);
        check_inst("i23", i23_d1, i23_d10, i23_bin, i23_cy, i23_er, v23, cy23, er23);
        check_inst("lo", lo_d1, lo_d10, lo_bin, lo_cy, lo_er, vlo, cylo, erlo);
        check_inst("hi", hi_d1, hi_d10, hi_bin, hi_cy, hi_er, vhi, cyhi, erhi);
`ifdef BCD_CNT_DOWN_EN
        check_inst("m24", m24_d1, m24_d10, m24_bin, m24_cy, m24_er, v24, cy24, er24);
`endif
    endtask

    task automatic model_reset();
        v60 = 0;  cy60 = 0; er60 = 0;
        v23 = 23; cy23 = 0; er23 = 0;
        vlo = 0;  cylo = 0; erlo = 0;
        vhi = 0;  cyhi = 0; erhi = 0;
`ifdef BCD_CNT_DOWN_EN
        v24 = 0;  cy24 = 0; er24 = 0;
`endif
    endtask

    // One clock: model follows the inputs sampled at the rising edge, outputs checked at the falling edge.
    task automatic cycle();
        int n;
        bit c, e, lo_cy_seen;
        @(posedge clk);
        model_step(60, v60, clear, load, int'(ld1), int'(ld10), tick, enable, up_dn, n, c, e);
        v60 = n; cy60 = c; er60 = e;
        model_step(60, v23, clear, load, int'(ld1), int'(ld10), tick, enable, up_dn, n, c, e);
        v23 = n; cy23 = c; er23 = e;
`ifdef BCD_CNT_DOWN_EN
        model_step(24, v24, clear, load, int'(ld1), int'(ld10), tick, enable, up_dn, n, c, e);
        v24 = n; cy24 = c; er24 = e;
`endif
        lo_cy_seen = cylo;
        model_step(100, vhi, c_clear, 1'b0, 0, 0, lo_cy_seen, 1'b1, 1'b1, n, c, e);
        vhi = n; cyhi = c; erhi = e;
        model_step(100, vlo, c_clear, 1'b0, 0, 0, c_tick, 1'b1, 1'b1, n, c, e);
        vlo = n; cylo = c; erlo = e;
        @(negedge clk);
        cyc++;
        check_all();
        $display("txn %0d tick=%0b en=%0b up=%0b clr=%0b ld=%0b(%0d,%0d) m60=%0d i23=%0d lo=%0d hi=%0d",
                 cyc, tick, enable, up_dn, clear, load, ld10, ld1, v60, v23, vlo, vhi);
    endtask

    task automatic set_in(input bit tk, input bit en, input bit clr, input bit ld,
                          input logic [3:0] d10, input logic [3:0] d1);
        tick = tk; enable = en; clear = clr; load = ld; ld10 = d10; ld1 = d1;
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all();                                   // reset state

        // release with a tick present: that first edge counts
        set_in(1, 1, 0, 0, 4'd0, 4'd0);
        c_tick = 1'b1;
        reset_n = 1'b1;
        cycle();

        // clear everything, then 60 ticks on m60 and 100 on the cascade
        set_in(1, 1, 1, 0, 4'd0, 4'd0);
        c_clear = 1'b1;
        cycle();
        set_in(1, 1, 0, 0, 4'd0, 4'd0);
        c_clear = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            tick   = (i < 60);
            c_tick = (i < 100);
            cycle();
        end
        c_tick = 1'b0;
        check_eq("m60_after_60_ticks", int'(m60_bin), 0);
        check_eq("cascade_hi_reads_01", int'(hi_bin), 1);
        check_eq("cascade_lo_reads_00", int'(lo_bin), 0);

        // load 5,9 then wrap; load 6,0 rejected
        set_in(0, 1, 0, 1, 4'd5, 4'd9); cycle();
        set_in(1, 1, 0, 0, 4'd0, 4'd0); cycle();
        set_in(1, 1, 0, 1, 4'd6, 4'd0); cycle();
        // load 1,A rejected; clear+load+tick together -> 00
        set_in(0, 1, 0, 1, 4'd1, 4'd10); cycle();
        set_in(1, 1, 0, 0, 4'd0, 4'd0); cycle();
        set_in(1, 1, 1, 1, 4'd3, 4'd3); cycle();
        // load acts with enable low; enable low then holds through 10 ticks
        set_in(0, 0, 0, 1, 4'd4, 4'd2); cycle();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 0, 0, 0, 4'd0, 4'd0);
            cycle();
        end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            tick    = ($urandom_range(0, 99) < 60);
            enable  = ($urandom_range(0, 99) < 85);
            clear   = ($urandom_range(0, 99) < 3);
            load    = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 99) < 75) begin
                ld1  = 4'($urandom_range(0, 9));
                ld10 = 4'($urandom_range(0, 9));
            end else begin
                ld1  = 4'($urandom_range(0, 15));
                ld10 = 4'($urandom_range(0, 15));
            end
`ifdef BCD_CNT_DOWN_EN
            up_dn = ($urandom_range(0, 99) < 60);
`endif
            c_tick  = ($urandom_range(0, 99) < 70);
            c_clear = ($urandom_range(0, 99) < 1);
            cycle();
        end
        c_clear = 1'b0;
        up_dn   = 1'b1;

        // reset mid-count while a carry pulse is showing
        set_in(0, 1, 0, 1, 4'd5, 4'd9); cycle();
        set_in(1, 1, 0, 0, 4'd0, 4'd0); cycle();
        check_eq("carry_before_reset", int'(m60_cy), 1);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        check_eq("async_reset_i23_dec10", int'(i23_d10), 2);
        check_eq("async_reset_i23_dec1", int'(i23_d1), 3);
        @(negedge clk);
        set_in(1, 1, 0, 0, 4'd0, 4'd0);
        c_tick = 1'b1;
        reset_n = 1'b1;
        cycle();
        c_tick = 1'b0;

`ifdef BCD_CNT_DOWN_EN
        // down count: 00 -> top with carry, 10 -> 09
        set_in(0, 1, 1, 0, 4'd0, 4'd0); cycle();
        up_dn = 1'b0;
        set_in(1, 1, 0, 0, 4'd0, 4'd0); cycle();
        check_eq("down_m24_wrap_to_23", int'(m24_bin), 23);
        set_in(0, 1, 0, 1, 4'd1, 4'd0); cycle();
        set_in(1, 1, 0, 0, 4'd0, 4'd0); cycle();
        check_eq("down_m24_10_to_09", int'(m24_bin), 9);
        up_dn = 1'b1;
`endif

        set_in(0, 0, 0, 0, 4'd0, 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_counter_mod.md
BCD_COUNTER_MOD -- requirements
Module: bcd_counter_mod

Interface
REQ-001 The block SHALL have a parameter MODULO, default 60, giving the count modulus; legal range is 2..100, and any other value SHALL stop elaboration.
REQ-002 The block SHALL have a parameter INIT, default 0, giving the reset count value; legal range is 0..MODULO-1.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port tick_in, input, 1 bit: count strobe, one clk cycle wide, e.g. a usec, msec or sec pulse.
REQ-007 Port enable, input, 1 bit: when high, tick_in is honoured.
REQ-008 Port up_dn, input, 1 bit: 1 counts up, 0 counts down; present only with BCD_CNT_DOWN_EN.
REQ-009 Port clear, input, 1 bit: synchronous clear to 0.
REQ-010 Port load, input, 1 bit: synchronous load strobe.
REQ-011 Port load_dec1, input, 4 bits: BCD ones digit for load.
REQ-012 Port load_dec10, input, 4 bits: BCD tens digit for load.
REQ-013 Port dec1, output, 4 bits: registered BCD ones digit.
REQ-014 Port dec10, output, 4 bits: registered BCD tens digit.
REQ-015 Port cnt_bin, output, 7 bits: registered binary equal of 10*dec10+dec1.
REQ-016 Port carry, output, 1 bit: registered one-cycle wrap pulse, for cascading into the next stage's tick_in.
REQ-017 Port load_err, output, 1 bit: registered one-cycle pulse marking a rejected load.

Function
REQ-018 Priority per cycle SHALL be: clear, then load, then counting.
REQ-019 Counting occurs only when tick_in=1 and enable=1; otherwise the count SHALL hold.
REQ-020 Up count: the value SHALL go to value+1; from MODULO-1 it SHALL go to 0 with carry=1 in the same edge's update.
REQ-021 Digit rule: dec1 wraps 9->0 and increments dec10; dec1 and dec10 SHALL never hold a non-BCD code (A-F).
REQ-022 Outputs SHALL update on the first rising edge where tick_in=1 is sampled (latency 1), and carry SHALL be high for exactly that following cycle.
REQ-023 clear=1 SHALL set the value to 0 regardless of INIT, with carry=0; any tick that cycle SHALL be dropped.
REQ-024 load=1 with a valid value (both digits <=9 and 10*dec10+dec1 < MODULO) SHALL set dec1/dec10 to the load digits; any tick that cycle SHALL be dropped, and carry=0.
REQ-025 load=1 with an invalid value SHALL leave the count unchanged, drop any tick that cycle, and pulse load_err for one cycle.
REQ-026 clear and load SHALL act regardless of enable.
REQ-027 With MODULO=100, the wrap SHALL be 99->0, and cnt_bin SHALL cover 0..99.
REQ-028 carry and load_err SHALL be 0 on every cycle not named above.

Reset
REQ-029 reset_n=0 SHALL asynchronously set dec1/dec10 to the BCD value of INIT, cnt_bin=INIT, carry=0 and load_err=0.
REQ-030 Reset release SHALL take effect from the next rising edge, and a tick on that edge SHALL be counted.
REQ-031 Reset asserted mid-count SHALL abandon any pending carry immediately.

Configuration
REQ-032 Macro BCD_CNT_DOWN_EN defined: the up_dn port SHALL exist; with up_dn=0 the value goes value-1, and from 0 it goes to MODULO-1 with carry=1; dec1 borrows 0->9 and decrements dec10.
REQ-033 Macro BCD_CNT_DOWN_EN undefined: the up_dn port SHALL be absent and the block SHALL count up only.

Verification
REQ-034 MODULO=60, INIT=0: 60 ticks -> dec10:dec1 steps 00..59 then 00, with carry=1 only on the 59->00 update.
REQ-035 Load 5,9 -> value 59; next tick -> 00 and carry pulse; load 6,0 -> load_err=1 and value unchanged.
REQ-036 Load 1,A -> load_err=1; clear+load+tick in the same cycle -> value 00, carry=0, load_err=0.
REQ-037 enable=0 with 10 ticks -> value unchanged; reset_n=0 mid-count with INIT=23 -> dec10=2, dec1=3 asynchronously.
REQ-038 MODULO=100 via a cascade of two instances (carry to tick_in): 100 ticks -> first instance wraps 99->00 and second instance reads 01.
REQ-039 With BCD_CNT_DOWN_EN, up_dn=0, MODULO=24, value 00, one tick -> 23 and carry=1; value 10, one tick -> 09.
